// File: rtl/usr_ctrl_pkg.sv
// Shared encodings for the usr command sequencer: op codes (same as usr select),
// sequencer states and the default register width.
package usr_ctrl_pkg;

    localparam int DEFAULT_WIDTH = 4;

    localparam logic [1:0] OP_HOLD = 2'd0;
    localparam logic [1:0] OP_SHR  = 2'd1;
    localparam logic [1:0] OP_SHL  = 2'd2;
    localparam logic [1:0] OP_LOAD = 2'd3;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        SHIFT = 2'd2,
        RESP  = 2'd3
    } state_t;

endpackage

// File: rtl/usr.sv
// 4-bit universal shift register: hold, shift right, shift left, parallel load.
// One-cycle update on select; the serial outputs always show the current MSB/LSB.
module usr
    import usr_ctrl_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [1:0]       select,
    input  logic [WIDTH-1:0] p_din,
    input  logic             s_left_din,
    input  logic             s_right_din,
    output logic [WIDTH-1:0] p_dout,
    output logic             s_left_dout,
    output logic             s_right_dout
);

    logic [WIDTH-1:0] q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q <= '0;
        end else begin
            case (select)
                OP_SHR:  q <= {s_left_din, q[WIDTH-1:1]};
                OP_SHL:  q <= {q[WIDTH-2:0], s_right_din};
                OP_LOAD: q <= p_din;
                default: q <= q;
            endcase
        end
    end

    assign p_dout       = q;
    assign s_left_dout  = q[WIDTH-1];
    assign s_right_dout = q[0];

endmodule

// File: rtl/usr_ctrl.sv
// Sequences load/hold/shift commands onto a usr; LOAD takes 1 cycle, SHIFT n takes n cycles.
// One command in flight: cmd_ready drops from accept until the response is taken.
module usr_ctrl
    import usr_ctrl_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int CNT_W = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [1:0]       cmd_op,
    input  logic [WIDTH-1:0] cmd_data,
    input  logic [CNT_W-1:0] cmd_cnt,
    input  logic             cmd_fill,
    output logic [1:0]       usr_select,
    output logic [WIDTH-1:0] usr_p_din,
    output logic             usr_s_left_din,
    output logic             usr_s_right_din,
    input  logic [WIDTH-1:0] usr_p_dout,
    input  logic             usr_s_left_dout,
    input  logic             usr_s_right_dout,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [WIDTH-1:0] rsp_data,
    output logic [WIDTH-1:0] rsp_sout,
    output logic             busy
);

    state_t           state, state_nxt;
    logic [1:0]       op_q;
    logic [WIDTH-1:0] data_q;
    logic [WIDTH-1:0] sout_q;
    logic             fill_q;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] idx_q;
    logic [CNT_W-1:0] cnt_clamp;
    logic             accept;
    logic             shift_bit;
    logic             is_shift_op;

    assign cnt_clamp   = (cmd_cnt > CNT_W'(WIDTH)) ? CNT_W'(WIDTH) : cmd_cnt;
    assign accept      = (state == IDLE) && cmd_valid;
    assign is_shift_op = (cmd_op == OP_SHR) || (cmd_op == OP_SHL);
    // The bit leaving the register is the one present before the shifting edge.
    assign shift_bit   = (op_q == OP_SHR) ? usr_s_right_dout : usr_s_left_dout;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (cmd_valid) begin
                    if (cmd_op == OP_LOAD) begin
                        state_nxt = LOAD;
                    end else if (is_shift_op && (cnt_clamp != '0)) begin
                        state_nxt = SHIFT;
                    end else begin
                        state_nxt = RESP;
                    end
                end
            end
            LOAD:  state_nxt = RESP;
            SHIFT: begin
                if (idx_q == cnt_q - CNT_W'(1)) begin
                    state_nxt = RESP;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            op_q   <= OP_HOLD;
            data_q <= '0;
            fill_q <= 1'b0;
            cnt_q  <= '0;
            idx_q  <= '0;
            sout_q <= '0;
        end else if (accept) begin
            op_q   <= cmd_op;
            data_q <= cmd_data;
            fill_q <= cmd_fill;
            cnt_q  <= cnt_clamp;
            idx_q  <= '0;
            sout_q <= '0;
        end else if (state == SHIFT) begin
            for (int i = 0; i < WIDTH; i++) begin
                if (idx_q == CNT_W'(i)) begin
                    sout_q[i] <= shift_bit;
                end
            end
            idx_q <= idx_q + CNT_W'(1);
        end
    end

    // usr pins decode from registered state only, so reset parks the usr at once.
    always_comb begin
        usr_select      = OP_HOLD;
        usr_p_din       = '0;
        usr_s_left_din  = 1'b0;
        usr_s_right_din = 1'b0;
        case (state)
            LOAD: begin
                usr_select = OP_LOAD;
                usr_p_din  = data_q;
            end
            SHIFT: begin
                usr_select = op_q;
                if (op_q == OP_SHR) begin
                    usr_s_left_din = fill_q;
                end else begin
                    usr_s_right_din = fill_q;
                end
            end
            default: ;
        endcase
    end

    assign cmd_ready = (state == IDLE);
    assign busy      = (state != IDLE);
    assign rsp_valid = (state == RESP);
    assign rsp_data  = usr_p_dout;
    assign rsp_sout  = sout_q;

endmodule

// File: tb/tb_usr_ctrl.sv
// Directed bench for usr_ctrl driving a real usr; inputs change and outputs are
// sampled on the falling edge, expected values are hand-computed.
module tb_usr_ctrl;
    import usr_ctrl_pkg::*;

    localparam int WIDTH = 4;
    localparam int CNT_W = 3;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             usr_rst = 1'b1;
    logic             cmd_valid = 1'b0;
    logic             cmd_ready;
    logic [1:0]       cmd_op = 2'd0;
    logic [WIDTH-1:0] cmd_data = '0;
    logic [CNT_W-1:0] cmd_cnt = '0;
    logic             cmd_fill = 1'b0;
    logic [1:0]       usr_select;
    logic [WIDTH-1:0] usr_p_din;
    logic             usr_s_left_din;
    logic             usr_s_right_din;
    logic [WIDTH-1:0] usr_p_dout;
    logic             usr_s_left_dout;
    logic             usr_s_right_dout;
    logic             rsp_valid;
    logic             rsp_ready = 1'b0;
    logic [WIDTH-1:0] rsp_data;
    logic [WIDTH-1:0] rsp_sout;
    logic             busy;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    usr_ctrl #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
        .clk              (clk),
        .rst              (rst),
        .cmd_valid        (cmd_valid),
        .cmd_ready        (cmd_ready),
        .cmd_op           (cmd_op),
        .cmd_data         (cmd_data),
        .cmd_cnt          (cmd_cnt),
        .cmd_fill         (cmd_fill),
        .usr_select       (usr_select),
        .usr_p_din        (usr_p_din),
        .usr_s_left_din   (usr_s_left_din),
        .usr_s_right_din  (usr_s_right_din),
        .usr_p_dout       (usr_p_dout),
        .usr_s_left_dout  (usr_s_left_dout),
        .usr_s_right_dout (usr_s_right_dout),
        .rsp_valid        (rsp_valid),
        .rsp_ready        (rsp_ready),
        .rsp_data         (rsp_data),
        .rsp_sout         (rsp_sout),
        .busy             (busy)
    );

    usr #(.WIDTH(WIDTH)) u_usr (
        .clk          (clk),
        .rst          (usr_rst),
        .select       (usr_select),
        .p_din        (usr_p_din),
        .s_left_din   (usr_s_left_din),
        .s_right_din  (usr_s_right_din),
        .p_dout       (usr_p_dout),
        .s_left_dout  (usr_s_left_dout),
        .s_right_dout (usr_s_right_dout)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Present one command for one cycle; returns in the first cycle after acceptance.
    task automatic send(input logic [1:0] op, input logic [3:0] data,
                        input logic [2:0] cnt, input logic fill);
        check("send_ready", 32'(cmd_ready), 32'd1);
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_data  = data;
        cmd_cnt   = cnt;
        cmd_fill  = fill;
        @(negedge clk);
        cmd_valid = 1'b0;
    endtask

    task automatic take_rsp();
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        check("post_rsp_ready", 32'(cmd_ready), 32'd1);
        check("post_rsp_valid", 32'(rsp_valid), 32'd0);
    endtask

    task automatic do_load(input logic [3:0] data);
        send(OP_LOAD, data, 3'd0, 1'b0);
        check("load_sel", 32'(usr_select), 32'd3);
        check("load_pdin", 32'(usr_p_din), 32'(data));
        check("load_busy", 32'(busy), 32'd1);
        check("load_no_rsp", 32'(rsp_valid), 32'd0);
        @(negedge clk);
        check("load_rsp_valid", 32'(rsp_valid), 32'd1);
        check("load_sel_off", 32'(usr_select), 32'd0);
        check("load_pdin_off", 32'(usr_p_din), 32'd0);
        check("load_rsp_data", 32'(rsp_data), 32'(data));
        check("load_rsp_sout", 32'(rsp_sout), 32'd0);
        take_rsp();
    endtask

    // n = number of active shift cycles expected after clamping.
    task automatic do_shift(input logic [1:0] op, input logic [2:0] cnt, input logic fill,
                            input int n, input logic [3:0] exp_data, input logic [3:0] exp_sout);
        send(op, 4'd0, cnt, fill);
        for (int i = 0; i < n; i++) begin
            check("shift_sel", 32'(usr_select), 32'(op));
            check("shift_ldin", 32'(usr_s_left_din), (op == OP_SHR) ? 32'(fill) : 32'd0);
            check("shift_rdin", 32'(usr_s_right_din), (op == OP_SHL) ? 32'(fill) : 32'd0);
            check("shift_no_rsp", 32'(rsp_valid), 32'd0);
            @(negedge clk);
        end
        check("shift_rsp_valid", 32'(rsp_valid), 32'd1);
        check("shift_sel_off", 32'(usr_select), 32'd0);
        check("shift_rsp_data", 32'(rsp_data), 32'(exp_data));
        check("shift_rsp_sout", 32'(rsp_sout), 32'(exp_sout));
        take_rsp();
    endtask

    initial begin
        repeat (2) @(negedge clk);
        check("rst_cmd_ready", 32'(cmd_ready), 32'd1);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst_sel", 32'(usr_select), 32'd0);
        check("rst_pdin", 32'(usr_p_din), 32'd0);
        check("rst_sdin", 32'({usr_s_left_din, usr_s_right_din}), 32'd0);
        check("rst_sout", 32'(rsp_sout), 32'd0);
        rst     = 1'b0;
        usr_rst = 1'b0;
        @(negedge clk);

        do_load(4'b1101);

        do_load(4'b1101);
        do_shift(OP_SHR, 3'd3, 1'b1, 3, 4'b1111, 4'b0101);

        do_load(4'b1101);
        do_shift(OP_SHL, 3'd2, 1'b0, 2, 4'b0100, 4'b0011);

        // Count 7 clamps to 4: whole word leaves LSB-first.
        do_load(4'b1101);
        do_shift(OP_SHR, 3'd7, 1'b0, 4, 4'b0000, 4'b1101);

        do_load(4'b1010);
        do_shift(OP_SHL, 3'd0, 1'b1, 0, 4'b1010, 4'b0000);
        do_shift(OP_HOLD, 3'd3, 1'b1, 0, 4'b1010, 4'b0000);

        // Backpressure with a second command waiting.
        do_load(4'b1101);
        do_shift(OP_SHR, 3'd1, 1'b0, 1, 4'b0110, 4'b0001);
        send(OP_HOLD, 4'd0, 3'd0, 1'b0);
        cmd_valid = 1'b1;
        cmd_op    = OP_LOAD;
        cmd_data  = 4'b1111;
        for (int i = 0; i < 5; i++) begin
            check("bp_rsp_valid", 32'(rsp_valid), 32'd1);
            check("bp_rsp_data", 32'(rsp_data), 32'b0110);
            check("bp_rsp_sout", 32'(rsp_sout), 32'd0);
            check("bp_cmd_ready", 32'(cmd_ready), 32'd0);
            check("bp_sel", 32'(usr_select), 32'd0);
            @(negedge clk);
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        check("bp_idle_ready", 32'(cmd_ready), 32'd1);
        check("bp_idle_sel", 32'(usr_select), 32'd0);
        @(negedge clk);
        cmd_valid = 1'b0;
        check("bp_second_sel", 32'(usr_select), 32'd3);
        check("bp_second_pdin", 32'(usr_p_din), 32'b1111);
        @(negedge clk);
        check("bp_second_rsp", 32'(rsp_valid), 32'd1);
        check("bp_second_data", 32'(rsp_data), 32'b1111);
        take_rsp();

        // Reset in the 2nd cycle of a 4-bit right shift; usr keeps its one shifted step.
        do_load(4'b1101);
        send(OP_SHR, 4'd0, 3'd4, 1'b1);
        check("rst_mid_sel1", 32'(usr_select), 32'd1);
        @(negedge clk);
        check("rst_mid_sel2", 32'(usr_select), 32'd1);
        rst = 1'b1;
        #1;
        check("rst_mid_sel_off", 32'(usr_select), 32'd0);
        check("rst_mid_ldin", 32'(usr_s_left_din), 32'd0);
        check("rst_mid_rsp", 32'(rsp_valid), 32'd0);
        check("rst_mid_ready", 32'(cmd_ready), 32'd1);
        @(negedge clk);
        rst = 1'b0;
        check("rst_mid_usr_kept", 32'(usr_p_dout), 32'b1110);
        check("rst_mid_sout", 32'(rsp_sout), 32'd0);
        @(negedge clk);
        check("rst_mid_no_rsp", 32'(rsp_valid), 32'd0);
        do_load(4'b0011);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
